// File: rtl/acc_and16.sv
// acc_and16 -- frame AND accumulator.
//
// Accepts N 16-bit words per frame through a valid/ready handshake. It ANDs
// them bitwise and presents the frame result through a second valid/ready
// handshake. The result stays stable until the downstream side takes it.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset (highest priority)
//   clr        synchronous frame flush (below rst, above handshakes)
//   in_valid   upstream word present on in_a
//   in_a       upstream word
//   in_ready   block can accept a word this cycle (state decode only)
//   out_valid  frame result present on out_y (state decode only)
//   out_y      bitwise AND of the N words of the last completed frame
//   out_zero   high when out_y == 0
//   out_ready  downstream accepts the result
//   cnt        words accepted in the current frame
module acc_and16 #(
  parameter int unsigned N = 4  // words per frame, legal range 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_y,
  output logic        out_zero,
  input  logic        out_ready,
  output logic [7:0]  cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The accept that completes a frame arrives while cnt still holds N-1.
  // With N=1 this is 0, so IDLE goes straight to HOLD.
  localparam logic [7:0] LAST_CNT = 8'(N - 1);

  state_t      r_state;
  logic [15:0] r_acc;
  logic [7:0]  r_cnt;
  logic [15:0] r_out_y;
  logic        r_out_zero;

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_and;

  // Both handshake flags come from the state register alone. This keeps
  // in_valid and out_ready off any combinational path to the outputs.
  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign out_y     = r_out_y;
  assign out_zero  = r_out_zero;
  assign cnt       = r_cnt;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_and    = r_acc & in_a;

  // NOTE: every register here uses non-blocking assignments. Then each
  // branch reads the pre-edge values of r_acc/r_cnt, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= 16'hFFFF;
      r_cnt      <= 8'd0;
      r_out_y    <= 16'h0000;
      r_out_zero <= 1'b1;
    end else if (clr) begin
      // Flush the frame. The result registers keep the last delivered value.
      r_state <= IDLE;
      r_acc   <= 16'hFFFF;
      r_cnt   <= 8'd0;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc <= w_and;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
              r_state    <= HOLD;
              r_out_y    <= w_and;
              r_out_zero <= (w_and == 16'h0000);
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // cnt stays at N and the result stays put until it is taken.
          if (out_ready) begin
            r_state <= IDLE;
            r_acc   <= 16'hFFFF;
            r_cnt   <= 8'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_acc   <= 16'hFFFF;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_and16.sv
// Testbench for acc_and16. It drives two instances from the same stimulus:
// one with N=4 and one with N=1. A queue-based frame model of each instance
// is compared against every output on every falling edge. Literal
// expectations at key points pin the model.
module tb_acc_and16;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [15:0] in_a;

  logic        rdy4, vld4, zero4, rdy1, vld1, zero1;
  logic [15:0] y4, y1;
  logic [7:0]  cnt4, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  acc_and16 #(.N(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_a(in_a),
    .in_ready(rdy4), .out_valid(vld4), .out_y(y4), .out_zero(zero4),
    .out_ready(out_ready), .cnt(cnt4)
  );

  acc_and16 #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_a(in_a),
    .in_ready(rdy1), .out_valid(vld1), .out_y(y1), .out_zero(zero1),
    .out_ready(out_ready), .cnt(cnt1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is the list of words accepted so far. When it holds N words the
  // result is their AND, and the frame waits for the downstream handshake.
  typedef logic [15:0] word_q_t [$];
  word_q_t     m_q    [2];
  bit          m_hold [2];
  logic [15:0] m_y    [2];
  bit          m_zero [2];
  int          m_n    [2] = '{4, 1};
  bit          m_init = 1'b0;

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_q[k].delete();
        m_hold[k] = 1'b0;
        m_y[k]    = 16'h0000;
        m_zero[k] = 1'b1;
      end else if (clr) begin
        m_q[k].delete();
        m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_hold[k] = 1'b0;
          m_q[k].delete();
        end
      end else if (in_valid) begin
        m_q[k].push_back(in_a);
        if (m_q[k].size() == m_n[k]) begin
          m_y[k] = 16'hFFFF;
          for (int j = 0; j < m_q[k].size(); j++) m_y[k] = m_y[k] & m_q[k][j];
          m_zero[k] = (m_y[k] == 16'h0000);
          m_hold[k] = 1'b1;
        end
      end
    end
    if (rst) m_init = 1'b1;
  end

  task automatic check_inst(input string tag, input int k, input logic rdy, input logic vld,
                            input logic [15:0] y, input logic zero, input logic [7:0] c);
    check({tag, ".in_ready"},  16'(rdy),  16'(!m_hold[k]));
    check({tag, ".out_valid"}, 16'(vld),  16'(m_hold[k]));
    check({tag, ".out_y"},     y,         m_y[k]);
    check({tag, ".out_zero"},  16'(zero), 16'(m_zero[k]));
    check({tag, ".cnt"},       16'(c),    16'(m_q[k].size()));
  endtask

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check_inst("model_n4", 0, rdy4, vld4, y4, zero4, cnt4);
      check_inst("model_n1", 1, rdy1, vld1, y1, zero1, cnt1);
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply inputs just after a falling edge, then wait for the next falling
  // edge. The outputs seen afterwards reflect the rising edge in between.
  task automatic drive(input logic v, input logic [15:0] a);
    in_valid = v;
    in_a     = a;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = 16'hDEAD; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset.in_ready", 16'(rdy4), 16'h1);
    check("reset.out_valid", 16'(vld4), 16'h0);
    check("reset.out_y", y4, 16'h0000);
    check("reset.out_zero", 16'(zero4), 16'h1);
    check("reset.cnt", 16'(cnt4), 16'h0);
    rst = 1'b0;

    // Four back-to-back words, result taken at once.
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hF0F0);
    drive(1'b1, 16'hFF00);
    drive(1'b1, 16'h8FFF);
    check("basic.out_valid", 16'(vld4), 16'h1);
    check("basic.out_y", y4, 16'h8000);
    check("basic.out_zero", 16'(zero4), 16'h0);
    check("basic.cnt", 16'(cnt4), 16'h4);
    drive(1'b0, 16'h0000);
    check("basic.one_cycle", 16'(vld4), 16'h0);
    check("basic.cnt_clear", 16'(cnt4), 16'h0);
    check("basic.y_kept", y4, 16'h8000);

    // Backpressure: zero result held for 3 cycles. Words offered meanwhile are ignored.
    out_ready = 1'b0;
    drive(1'b1, 16'h00FF);
    drive(1'b1, 16'hFF00);
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      check("bp.out_valid", 16'(vld4), 16'h1);
      check("bp.out_y", y4, 16'h0000);
      check("bp.out_zero", 16'(zero4), 16'h1);
      check("bp.in_ready", 16'(rdy4), 16'h0);
      check("bp.cnt", 16'(cnt4), 16'h4);
      if (i < 2) drive(1'b1, 16'h0000);
    end
    out_ready = 1'b1;
    drive(1'b0, 16'h0000);
    check("bp.idle", 16'(vld4), 16'h0);
    check("bp.cnt0", 16'(cnt4), 16'h0);

    // Gaps in in_valid.
    begin
      logic        v_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] a_seq [7] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1230};
      logic [7:0]  c_seq [7] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4};
      for (int i = 0; i < 7; i++) begin
        drive(v_seq[i], a_seq[i]);
        check("gaps.cnt", 16'(cnt4), 16'(c_seq[i]));
      end
      check("gaps.out_y", y4, 16'h1230);
      check("gaps.out_valid", 16'(vld4), 16'h1);
      drive(1'b0, 16'h0000);
    end

    // A flush mid-frame, with a coincident accept, discards the partial frame.
    drive(1'b1, 16'h0000);
    drive(1'b1, 16'h0000);
    check("clr.pre_cnt", 16'(cnt4), 16'h2);
    clr = 1'b1;
    drive(1'b1, 16'h0000);
    clr = 1'b0;
    check("clr.cnt0", 16'(cnt4), 16'h0);
    check("clr.in_ready", 16'(rdy4), 16'h1);
    drive(1'b1, 16'hAAAA);
    drive(1'b1, 16'h5555);
    drive(1'b1, 16'hFFFF);
    check("clr.not_yet", 16'(vld4), 16'h0);
    drive(1'b1, 16'hFFFF);
    check("clr.out_valid", 16'(vld4), 16'h1);
    check("clr.out_y", y4, 16'h0000);
    check("clr.out_zero", 16'(zero4), 16'h1);
    drive(1'b0, 16'h0000);

    // Reset while a result is pending.
    out_ready = 1'b0;
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hF0F0);
    drive(1'b1, 16'hFF00);
    drive(1'b1, 16'h8FFF);
    check("rsthold.y", y4, 16'h8000);
    rst = 1'b1;
    drive(1'b0, 16'h0000);
    rst = 1'b0;
    check("rsthold.out_valid", 16'(vld4), 16'h0);
    check("rsthold.out_y", y4, 16'h0000);
    check("rsthold.cnt", 16'(cnt4), 16'h0);
    check("rsthold.in_ready", 16'(rdy4), 16'h1);
    check("rsthold.out_zero", 16'(zero4), 16'h1);

    // Single-word frames (N=1 instance), then a flush while holding.
    drive(1'b1, 16'h3C3C);
    check("n1.out_valid", 16'(vld1), 16'h1);
    check("n1.out_y", y1, 16'h3C3C);
    check("n1.cnt", 16'(cnt1), 16'h1);
    clr = 1'b1;
    drive(1'b0, 16'h0000);
    clr = 1'b0;
    check("n1.clr_valid", 16'(vld1), 16'h0);
    check("n1.clr_y_kept", y1, 16'h3C3C);
    out_ready = 1'b1;
    drive(1'b1, 16'hC3C3);
    drive(1'b1, 16'hFFFF);
    check("n1.second_y", y1, 16'hC3C3);
    drive(1'b0, 16'h0000);
    drive(1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
